// File: rtl/add_sub_rr_sched.sv
// ----------------------------------------------------------------------------
// add_sub_rr_sched
//
// Round-robin scheduler that shares a single WIDTH-bit add/subtract datapath
// between two requesters. A granted request is latched in IDLE, computed in
// EXEC (one cycle), and presented on the response channel in RESP until the
// consumer accepts it. The ID of the last served requester decides ties, so
// two continuously active requesters are served alternately.
//
// Parameters:
//   WIDTH  operand / result width in bits
//   CNT_W  width of the completed-operation counter (wraps)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req0_*       requester 0: valid/ready handshake, operands a/b, select
//   req1_*       requester 1: valid/ready handshake, operands a/b, select
//                (select: 0 = a+b, 1 = a-b)
//   resp_valid   result available (high in RESP)
//   resp_ready   consumer accepts the result
//   resp_id      requester that owns the result
//   resp_result  a +/- b modulo 2^WIDTH
//   busy         high while an operation is in EXEC or RESP
//   op_count     number of completed responses, wraps
//
// Optional feature (macro ADD_SUB_SCHED_FLAGS_EN):
//   resp_carry   carry-out of the operation (for subtract, 1 = no borrow)
//   resp_ovf     signed two's-complement overflow
// ----------------------------------------------------------------------------
module add_sub_rr_sched #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_select,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_select,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
`ifdef ADD_SUB_SCHED_FLAGS_EN
    ,
    output logic             resp_carry,
    output logic             resp_ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic             last_grant;
    logic             grant_any;
    logic             grant_id;
    logic             accept;
    logic             resp_fire;

    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic             lat_select;
    logic             lat_id;

    // Subtraction is a + ~b + 1: invert b and feed select in as the carry-in.
    logic [WIDTH-1:0] operand_b;
`ifdef ADD_SUB_SCHED_FLAGS_EN
    logic [WIDTH:0]   sum;
`else
    logic [WIDTH-1:0] sum;
`endif

    // ------------------------------------------------------------------------
    // Arbitration: a lone valid requester wins; on a tie the requester that
    // was not served last wins.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~last_grant;
        end else if (req0_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
        end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign accept    = (state == IDLE) && grant_any;
    assign resp_fire = (state == RESP) && resp_ready;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept)    next_state = EXEC;
            EXEC:                   next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------------
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (accept) begin
            req0_ready = ~grant_id;
            req1_ready =  grant_id;
        end
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    assign operand_b = lat_select ? ~lat_b : lat_b;

`ifdef ADD_SUB_SCHED_FLAGS_EN
    assign sum = {1'b0, lat_a} + {1'b0, operand_b} + {{WIDTH{1'b0}}, lat_select};
`else
    assign sum = lat_a + operand_b + {{(WIDTH-1){1'b0}}, lat_select};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_a       <= '0;
            lat_b       <= '0;
            lat_select  <= 1'b0;
            lat_id      <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            last_grant  <= 1'b1;
            op_count    <= '0;
        end else begin
            if (accept) begin
                lat_a      <= grant_id ? req1_a      : req0_a;
                lat_b      <= grant_id ? req1_b      : req0_b;
                lat_select <= grant_id ? req1_select : req0_select;
                lat_id     <= grant_id;
            end
            if (state == EXEC) begin
                resp_id     <= lat_id;
                resp_result <= sum[WIDTH-1:0];
            end
            // Fairness history only advances once the result is delivered.
            if (resp_fire) begin
                last_grant <= resp_id;
                op_count   <= op_count + 1'b1;
            end
        end
    end

`ifdef ADD_SUB_SCHED_FLAGS_EN
    // Overflow: both effective operands share a sign and the result does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_carry <= 1'b0;
            resp_ovf   <= 1'b0;
        end else if (state == EXEC) begin
            resp_carry <= sum[WIDTH];
            resp_ovf   <= (lat_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                          (sum[WIDTH-1]   != lat_a[WIDTH-1]);
        end
    end
`endif

endmodule
